// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register-number width and forwarding select encodings.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;
    localparam logic [FWD_W-1:0] FWD_BAD = 2'b11;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator; MEM takes priority over WB, r0 never forwards.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_wa,
    input  logic             mem_we,
    input  logic             mem_ld,
    input  logic [REG_W-1:0] wb_wa,
    input  logic             wb_we,
    output logic [FWD_W-1:0] sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = (src != '0) && mem_we && (mem_wa == src);
    assign wb_hit  = (src != '0) && wb_we  && (wb_wa  == src);

    // A MEM-stage load has no result yet, so matching it is flagged as FWD_BAD.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = mem_ld ? FWD_BAD : FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/dest_pipe_fwd.sv
// Carries the EX destination through MEM/WB, selects operand forwarding,
// detects load-use hazards and counts stall cycles.
module dest_pipe_fwd
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush_ex,
    input  logic [REG_W-1:0] ex_wa,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    output logic [REG_W-1:0] mem_wa,
    output logic             mem_we,
    output logic             mem_ld,
    output logic [REG_W-1:0] wb_wa,
    output logic             wb_we,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             load_use_stall,
    output logic             fwd_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic ex_is_load;
    logic id_match;
    logic fwd_bad_now;

    fwd_sel u_fwd_a (
        .src    (ex_rs),
        .mem_wa (mem_wa),
        .mem_we (mem_we),
        .mem_ld (mem_ld),
        .wb_wa  (wb_wa),
        .wb_we  (wb_we),
        .sel    (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src    (ex_rt),
        .mem_wa (mem_wa),
        .mem_we (mem_we),
        .mem_ld (mem_ld),
        .wb_wa  (wb_wa),
        .wb_we  (wb_we),
        .sel    (fwd_b)
    );

    // Load-use hazard is judged on current EX contents, regardless of flush_ex.
    always_comb begin
        ex_is_load     = ex_mem_to_reg && ex_reg_write && (ex_wa != '0);
        id_match       = (id_rs_used && (id_rs == ex_wa)) ||
                         (id_rt_used && (id_rt == ex_wa));
        load_use_stall = ex_is_load && id_match;
        fwd_bad_now    = (fwd_a == FWD_BAD) || (fwd_b == FWD_BAD);
    end

    // EX->MEM->WB destination pipeline; r0 writes are dropped at MEM entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wa <= '0;
            mem_we <= 1'b0;
            mem_ld <= 1'b0;
            wb_wa  <= '0;
            wb_we  <= 1'b0;
        end else if (en) begin
            mem_we <= ex_reg_write && (ex_wa != '0) && !flush_ex;
            mem_ld <= ex_mem_to_reg && ex_reg_write && !flush_ex;
            mem_wa <= flush_ex ? '0 : ex_wa;
            wb_wa  <= mem_wa;
            wb_we  <= mem_we;
        end
    end

    // Sticky error and saturating stall counter, both frozen while en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_err   <= 1'b0;
            stall_cnt <= '0;
        end else if (en) begin
            if (fwd_bad_now) begin
                fwd_err <= 1'b1;
            end
            if (load_use_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
